t04_rv32i_datapath: RTL and testbench
=====================================

// Module: t04_rv32i_datapath
// PURPOSE
// - RV32I multi-cycle datapath for team 04: PC, register file, decoder, ALU, branch/jump unit, writeback mux.
// - Executes one instruction per i_ack handshake.
// - Load/store instructions stall on d_ack from the memory interface.
// - Sits between the instruction/data memory handler and the top-level CPU wrapper.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset.
// PORTS
// - clk            in   1   system clock; all state updates on rising edge.
// - rst            in   1   asynchronous, active-low reset.
// - i_ack          in   1   instruction valid this cycle; latch `instruction`.
// - d_ack          in   1   data memory access complete; `memload` valid for loads.
// - instruction    in   32  fetched instruction word.
// - memload        in   32  load data, right-aligned to final_address.
// - final_address  out  32  ALU result; byte address for load/store (rs1+imm).
// - mem_store      out  32  store data: rs2, masked per funct3 (SB: [7:0], SH: [15:0], SW: full).
// BEHAVIOUR
// - Required internal names for hierarchical checks:
//   - PC, RegD (rd index), write_back_data, Freeze.
//   - Register file instance `rf` with array `registers[0:31]`, 32 bits each.
// - Reset (rst=0, async):
//   - PC=RESET_PC, IR=0, all registers=0, state=FETCH.
//   - final_address=0, mem_store=0, Freeze=1.
// - FSM states: FETCH, EXEC, MEMWAIT.
// - FETCH: Freeze=1. On posedge with i_ack=1, latch instruction into IR and go to EXEC; else stay.
// - EXEC: decode IR combinationally.
//   - Non-memory op: on the next posedge write rd (if RegWrite and rd!=0), update PC, go to FETCH.
//     Total latency: 1 cycle after the i_ack edge.
//   - Load/store: go to MEMWAIT with Freeze=1; hold final_address and mem_store stable.
// - MEMWAIT: stay until d_ack=1.
//   - On the d_ack posedge, a load writes the extended memload into rd; a store writes nothing.
//   - Same edge: PC+=4, go to FETCH.
//   - d_ack arriving while in FETCH or EXEC is ignored.
// - Freeze=0 only in EXEC for non-memory ops and in MEMWAIT with d_ack=1; otherwise 1.
// - Supported ops:
//   - R-type: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//   - I-ALU: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
//   - LUI, AUIPC, JAL, JALR.
//   - Branches: BEQ BNE BLT BGE BLTU BGEU.
//   - Loads: LB LH LW LBU LHU. Stores: SB SH SW.
// - Unknown opcode, FENCE and SYSTEM: NOP, PC+=4, no register write.
// - Immediates: sign-extended per I/S/B/U/J formats.
// - Shift amount: low 5 bits of rs2 or imm.
// - Arithmetic: 32-bit, wraps modulo 2^32.
//   - SLT/BLT/BGE use signed compare; SLTU/BLTU/BGEU use unsigned compare.
// - Writeback select:
//   - ALU result for R/I/LUI/AUIPC.
//   - PC+4 for JAL/JALR.
//   - Extended memload for loads: LB/LH sign-extend; LBU/LHU zero-extend.
// - Next PC:
//   - JAL: PC+immJ.
//   - JALR: (rs1+immI) & ~1.
//   - Taken branch: PC+immB.
//   - Otherwise: PC+4.
// - JALR reads rs1 before writing rd, so rd==rs1 uses the old value.
// - x0 always reads 0; writes to x0 are discarded.
// - Register reads are combinational from `registers`.
// - Async reset asserted in EXEC or MEMWAIT aborts the instruction; no write occurs.
// - final_address and mem_store are combinational from the current IR and registers, valid in EXEC/MEMWAIT.
// TESTING
// - Preload x1=10, x2=20.
//   - ADD x3,x1,x2 -> x3=30.
//   - SUB x6,x2,x1 -> x6=10.
//   - AND x7 -> 0. OR x8 -> 30.
// - ADDI x9,x1,5 -> x9=15.
// - SLT x10,x1,x2 -> 1. SLTU x11 -> 1.
// - Write x0 -> x0 stays 0.
// - SW x3,0(x0):
//   - final_address=0, mem_store=30, Freeze=1 for 2 cycles.
//   - d_ack -> PC+=4, no register write.
// - LW x4,0(x0), memload=30 held with d_ack -> x4=30 written only on the d_ack edge.
// - JAL x5,4 at PC=p -> x5=p+4, PC=p+4.
// - Then JALR x12,x5,8 -> x12=p+8, PC=p+12.
// - Reset mid-MEMWAIT:
//   - PC=0, regs=0, state FETCH.
//   - d_ack without prior i_ack is ignored.

Source files
------------

// File: rtl/t04_rv32i_datapath.sv
// ---------------------------------------------------------------------------
// t04_rv32i_datapath
// Multi-cycle RV32I datapath: program counter, instruction register,
// register file, decoder, ALU, branch/jump unit and writeback mux.
// One instruction is executed per i_ack handshake. Loads and stores park in
// MEMWAIT until the memory interface signals d_ack.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   i_ack          instruction word valid this cycle (sampled in FETCH)
//   d_ack          data access complete (sampled in MEMWAIT)
//   instruction    fetched instruction word
//   memload        load data, right-aligned to final_address
//   final_address  ALU result; byte address (rs1+imm) for loads/stores
//   mem_store      store data: rs2 masked to byte/half/word by funct3
//
// Parameter
//   RESET_PC       value loaded into the PC on reset
// ---------------------------------------------------------------------------

// Register file: 32 x 32-bit, two combinational read ports, one write port.
// x0 reads as zero and ignores writes.
module t04_rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];

endmodule

module t04_rv32i_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ack,
  input  logic        d_ack,
  input  logic [31:0] instruction,
  input  logic [31:0] memload,
  output logic [31:0] final_address,
  output logic [31:0] mem_store
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] PC;
  logic [31:0] IR;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  RegD;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        reg_write;
  logic        branch_taken;
  logic        Freeze;
  logic        rf_we;

  logic [31:0] pc_plus4;
  logic [31:0] alu_result;
  logic [31:0] load_ext;
  logic [31:0] write_back_data;
  logic [31:0] next_pc;

  // Field extraction; everything downstream is decoded from the latched IR.
  assign opcode  = IR[6:0];
  assign RegD    = IR[11:7];
  assign funct3  = IR[14:12];
  assign rs1_idx = IR[19:15];
  assign rs2_idx = IR[24:20];

  assign imm_i = {{20{IR[31]}}, IR[31:20]};
  assign imm_s = {{20{IR[31]}}, IR[31:25], IR[11:7]};
  assign imm_b = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
  assign imm_u = {IR[31:12], 12'd0};
  assign imm_j = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};

  t04_rv32i_regfile rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (RegD),
    .wdata  (write_back_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // Shared ALU for R-type and I-type arithmetic. alt selects SUB (R-type
  // only) or the arithmetic right shift.
  function automatic logic [31:0] alu_fn(
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] sra;
    sra = $unsigned($signed(a) >>> b[4:0]);
    case (f3)
      3'b000:  alu_fn = alt ? (a - b) : (a + b);
      3'b001:  alu_fn = a << b[4:0];
      3'b010:  alu_fn = {31'd0, ($signed(a) < $signed(b))};
      3'b011:  alu_fn = {31'd0, (a < b)};
      3'b100:  alu_fn = a ^ b;
      3'b101:  alu_fn = alt ? sra : (a >> b[4:0]);
      3'b110:  alu_fn = a | b;
      default: alu_fn = a & b;
    endcase
  endfunction

  // Instruction class flags. Anything not listed (FENCE, SYSTEM, unknown)
  // falls through as a NOP that only advances the PC.
  always_comb begin
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_mem    = is_load || is_store;
    reg_write = (opcode == OPC_OP)    || (opcode == OPC_OPIMM) ||
                (opcode == OPC_LUI)   || (opcode == OPC_AUIPC) ||
                (opcode == OPC_JAL)   || (opcode == OPC_JALR)  ||
                (opcode == OPC_LOAD);
  end

  // ALU result doubles as the effective address, so the default is
  // rs1+immI which covers loads and JALR.
  always_comb begin
    alu_result = rs1_val + imm_i;
    case (opcode)
      OPC_OP:    alu_result = alu_fn(funct3, IR[30], rs1_val, rs2_val);
      OPC_OPIMM: alu_result = alu_fn(funct3, IR[30] && (funct3 == 3'b101), rs1_val, imm_i);
      OPC_LUI:   alu_result = imm_u;
      OPC_AUIPC: alu_result = PC + imm_u;
      OPC_STORE: alu_result = rs1_val + imm_s;
      default:   alu_result = rs1_val + imm_i;
    endcase
  end

  // Branch condition from funct3; unused encodings never branch.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_taken = (rs1_val <  rs2_val);
      3'b111:  branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  // Load data is already right-aligned; only width and extension differ.
  always_comb begin
    case (funct3)
      3'b000:  load_ext = {{24{memload[7]}}, memload[7:0]};
      3'b001:  load_ext = {{16{memload[15]}}, memload[15:0]};
      3'b100:  load_ext = {24'd0, memload[7:0]};
      3'b101:  load_ext = {16'd0, memload[15:0]};
      default: load_ext = memload;
    endcase
  end

  // Store data is masked to the access width so the memory side can
  // write it without looking at funct3 again.
  always_comb begin
    case (funct3[1:0])
      2'b00:   mem_store = {24'd0, rs2_val[7:0]};
      2'b01:   mem_store = {16'd0, rs2_val[15:0]};
      default: mem_store = rs2_val;
    endcase
  end

  assign final_address = alu_result;
  assign pc_plus4      = PC + 32'd4;

  // Writeback select: link address for jumps, extended data for loads.
  always_comb begin
    if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
      write_back_data = pc_plus4;
    end else if (is_load) begin
      write_back_data = load_ext;
    end else begin
      write_back_data = alu_result;
    end
  end

  // JALR target uses the pre-write rs1, so rd==rs1 sees the old value.
  always_comb begin
    next_pc = pc_plus4;
    if (opcode == OPC_JAL) begin
      next_pc = PC + imm_j;
    end else if (opcode == OPC_JALR) begin
      next_pc = (rs1_val + imm_i) & ~32'd1;
    end else if ((opcode == OPC_BRANCH) && branch_taken) begin
      next_pc = PC + imm_b;
    end
  end

  // Freeze drops only in the cycle whose closing edge commits the
  // instruction; it is also what gates the register-file write.
  assign Freeze = !(((state == EXEC) && !is_mem) || ((state == MEMWAIT) && d_ack));
  assign rf_we  = !Freeze && ((state == MEMWAIT) ? is_load : reg_write);

  // Sequencer: FETCH waits for i_ack, EXEC commits non-memory ops in one
  // cycle, MEMWAIT holds loads/stores until d_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      PC    <= RESET_PC;
      IR    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (i_ack) begin
            IR    <= instruction;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_mem) begin
            state <= MEMWAIT;
          end else begin
            PC    <= next_pc;
            state <= FETCH;
          end
        end
        MEMWAIT: begin
          if (d_ack) begin
            PC    <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_t04_rv32i_datapath.sv
// ---------------------------------------------------------------------------
// tb_t04_rv32i_datapath
// Self-checking bench for t04_rv32i_datapath. Instructions are produced
// from mnemonics and operands; a small architectural model (register array
// plus PC) tracks the expected state from the ISA rules.
// ---------------------------------------------------------------------------
module tb_t04_rv32i_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ack = 1'b0;
  logic        d_ack = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic [31:0] memload = 32'd0;
  logic [31:0] final_address;
  logic [31:0] mem_store;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  typedef enum int {A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND} alu_t;

  t04_rv32i_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ack         (i_ack),
    .d_ack         (d_ack),
    .instruction   (instruction),
    .memload       (memload),
    .final_address (final_address),
    .mem_store     (mem_store)
  );

  always #5 clk = ~clk;

  // Encoders from mnemonic/operands to instruction words
  function automatic logic [2:0] f3_of(input alu_t op);
    case (op)
      A_ADD, A_SUB: return 3'd0;
      A_SLL:        return 3'd1;
      A_SLT:        return 3'd2;
      A_SLTU:       return 3'd3;
      A_XOR:        return 3'd4;
      A_SRL, A_SRA: return 3'd5;
      A_OR:         return 3'd6;
      default:      return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input alu_t op, input int rd, input int rs1, input int rs2);
    logic [6:0] f7;
    f7 = ((op == A_SUB) || (op == A_SRA)) ? 7'h20 : 7'h00;
    return {f7, 5'(rs2), 5'(rs1), f3_of(op), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input int rd, input int rs1,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input int rs1, input int rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], 5'(rs2), 5'(rs1), f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] opc, input int rd, input logic [19:0] imm);
    return {imm, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Reference arithmetic by mnemonic
  function automatic logic [31:0] ref_alu(input alu_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      A_ADD:   r = a + b;
      A_SUB:   r = a - b;
      A_SLL:   r = a << b[4:0];
      A_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      A_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      A_XOR:   r = a ^ b;
      A_SRL:   r = a >> b[4:0];
      A_SRA:   r = $signed(a) >>> b[4:0];
      A_OR:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // Drivers: fetch leaves the DUT in EXEC, step advances one edge
  task automatic fetch(input logic [31:0] ir);
    @(negedge clk);
    instruction = ir;
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
    instruction = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [31:0] ir, input int rd, input logic [31:0] val);
    fetch(ir);
    step();
    if (rd != 0) m_regs[rd] = val;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic do_r(input alu_t op, input int rd, input int rs1, input int rs2);
    do_alu(enc_r(op, rd, rs1, rs2), rd, ref_alu(op, m_regs[rs1], m_regs[rs2]));
  endtask

  task automatic do_i(input alu_t op, input int rd, input int rs1, input logic [11:0] imm);
    logic [11:0] enc_imm;
    logic [31:0] b;
    enc_imm = imm;
    b = sext12(imm);
    if ((op == A_SLL) || (op == A_SRL) || (op == A_SRA)) begin
      enc_imm = {((op == A_SRA) ? 7'h20 : 7'h00), imm[4:0]};
      b = {27'd0, imm[4:0]};
    end
    do_alu(enc_i(7'b0010011, rd, rs1, f3_of(op), enc_imm), rd, ref_alu(op, m_regs[rs1], b));
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #11;
    n_cmp++; if (dut.PC !== 32'd0) begin n_err++; $display("[TB] FAIL reset_pc: got %h expected %h", dut.PC, 32'd0); end
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL reset_freeze: got %b expected 1", dut.Freeze); end
    n_cmp++; if (final_address !== 32'd0) begin n_err++; $display("[TB] FAIL reset_addr: got %h expected 0", final_address); end
    n_cmp++; if (mem_store !== 32'd0) begin n_err++; $display("[TB] FAIL reset_store: got %h expected 0", mem_store); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++; if (dut.rf.registers[i] !== 32'd0) begin n_err++; $display("[TB] FAIL reset_x%0d: got %h expected 0", i, dut.rf.registers[i]); end
    end
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_directed();
    int chk_rd [10] = '{1, 2, 3, 6, 7, 8, 9, 10, 11, 0};
    logic [31:0] chk_v [10] = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd0, 32'd30, 32'd15, 32'd1, 32'd1, 32'd0};
    logic [31:0] p;
    do_i(A_ADD, 1, 0, 12'd10);
    do_i(A_ADD, 2, 0, 12'd20);
    do_r(A_ADD, 3, 1, 2);
    do_r(A_SUB, 6, 2, 1);
    do_r(A_AND, 7, 1, 2);
    do_r(A_OR, 8, 1, 2);
    do_i(A_ADD, 9, 1, 12'd5);
    do_r(A_SLT, 10, 1, 2);
    do_r(A_SLTU, 11, 1, 2);
    do_i(A_ADD, 0, 1, 12'd7);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dut.rf.registers[chk_rd[i]] !== chk_v[i]) begin
        n_err++; $display("[TB] FAIL dir_x%0d: got %h expected %h", chk_rd[i], dut.rf.registers[chk_rd[i]], chk_v[i]);
      end
    end
    n_cmp++; if (dut.PC !== 32'd40) begin n_err++; $display("[TB] FAIL dir_pc: got %h expected %h", dut.PC, 32'd40); end

    // SW x3,0(x0)
    fetch(enc_s(3'd2, 0, 3, 12'd0));
    n_cmp++; if (final_address !== 32'd0) begin n_err++; $display("[TB] FAIL sw_addr: got %h expected 0", final_address); end
    n_cmp++; if (mem_store !== 32'd30) begin n_err++; $display("[TB] FAIL sw_data: got %h expected %h", mem_store, 32'd30); end
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL sw_freeze_exec: got %b expected 1", dut.Freeze); end
    step();
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL sw_freeze_wait: got %b expected 1", dut.Freeze); end
    n_cmp++; if (dut.PC !== 32'd40) begin n_err++; $display("[TB] FAIL sw_pc_hold: got %h expected %h", dut.PC, 32'd40); end
    d_ack = 1'b1;
    step();
    d_ack = 1'b0;
    m_pc = m_pc + 32'd4;
    n_cmp++; if (dut.PC !== 32'd44) begin n_err++; $display("[TB] FAIL sw_pc: got %h expected %h", dut.PC, 32'd44); end
    n_cmp++; if (dut.rf.registers[0] !== 32'd0) begin n_err++; $display("[TB] FAIL sw_x0: got %h expected 0", dut.rf.registers[0]); end

    // LW x4,0(x0) with memload=30
    fetch(enc_i(7'b0000011, 4, 0, 3'd2, 12'd0));
    step();
    memload = 32'd30;
    step();
    n_cmp++; if (dut.rf.registers[4] !== 32'd0) begin n_err++; $display("[TB] FAIL lw_early: got %h expected 0", dut.rf.registers[4]); end
    d_ack = 1'b1;
    #1;
    n_cmp++; if (dut.rf.registers[4] !== 32'd0) begin n_err++; $display("[TB] FAIL lw_before_edge: got %h expected 0", dut.rf.registers[4]); end
    step();
    d_ack = 1'b0;
    m_regs[4] = 32'd30;
    m_pc = m_pc + 32'd4;
    n_cmp++; if (dut.rf.registers[4] !== 32'd30) begin n_err++; $display("[TB] FAIL lw_x4: got %h expected %h", dut.rf.registers[4], 32'd30); end
    n_cmp++; if (dut.PC !== 32'd48) begin n_err++; $display("[TB] FAIL lw_pc: got %h expected %h", dut.PC, 32'd48); end

    // JAL x5,4 then JALR x12,x5,8
    p = 32'd48;
    do_alu(enc_j(5, 21'd4), 5, p + 32'd4);
    m_pc = p + 32'd4;
    n_cmp++; if (dut.rf.registers[5] !== p + 32'd4) begin n_err++; $display("[TB] FAIL jal_link: got %h expected %h", dut.rf.registers[5], p + 32'd4); end
    n_cmp++; if (dut.PC !== p + 32'd4) begin n_err++; $display("[TB] FAIL jal_pc: got %h expected %h", dut.PC, p + 32'd4); end
    do_alu(enc_i(7'b1100111, 12, 5, 3'd0, 12'd8), 12, p + 32'd8);
    m_pc = p + 32'd12;
    n_cmp++; if (dut.rf.registers[12] !== p + 32'd8) begin n_err++; $display("[TB] FAIL jalr_link: got %h expected %h", dut.rf.registers[12], p + 32'd8); end
    n_cmp++; if (dut.PC !== p + 32'd12) begin n_err++; $display("[TB] FAIL jalr_pc: got %h expected %h", dut.PC, p + 32'd12); end
  endtask

  task automatic test_dack_ignored();
    @(negedge clk);
    d_ack = 1'b1;
    memload = $urandom;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL dack_fetch_pc: got %h expected %h", dut.PC, m_pc); end
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL dack_fetch_freeze: got %b expected 1", dut.Freeze); end
    d_ack = 1'b0;
    do_i(A_ADD, 20, 0, 12'h123);
    n_cmp++; if (dut.rf.registers[20] !== 32'h123) begin n_err++; $display("[TB] FAIL dack_after_x20: got %h expected %h", dut.rf.registers[20], 32'h123); end
    n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL dack_after_pc: got %h expected %h", dut.PC, m_pc); end
  endtask

  task automatic test_random_alu();
    for (int r = 1; r < 32; r++) begin
      logic [19:0] u;
      u = 20'($urandom);
      do_alu(enc_u(7'b0110111, r, u), r, {u, 12'd0});
      do_i(A_ADD, r, r, 12'($urandom));
    end
    for (int k = 0; k < 60; k++) begin
      alu_t op;
      int rd, rs1, rs2;
      logic [11:0] imm;
      op  = alu_t'($urandom_range(0, 9));
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      imm = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (op == A_SUB) op = A_ADD;
        do_i(op, rd, rs1, imm);
      end else begin
        do_r(op, rd, rs1, rs2);
      end
      n_cmp++; if (dut.rf.registers[rd] !== m_regs[rd]) begin n_err++; $display("[TB] FAIL alu_%s_x%0d: got %h expected %h", op.name(), rd, dut.rf.registers[rd], m_regs[rd]); end
      n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL alu_pc: got %h expected %h", dut.PC, m_pc); end
    end
  endtask

  task automatic test_freeze_alu();
    fetch(enc_r(A_XOR, 21, 1, 2));
    n_cmp++; if (dut.Freeze !== 1'b0) begin n_err++; $display("[TB] FAIL freeze_exec_alu: got %b expected 0", dut.Freeze); end
    step();
    m_regs[21] = m_regs[1] ^ m_regs[2];
    m_pc = m_pc + 32'd4;
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL freeze_fetch: got %b expected 1", dut.Freeze); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 30; k++) begin
      int sel, rs1, rs2, off;
      logic [31:0] a, b;
      bit taken;
      sel = $urandom_range(0, 5);
      rs1 = $urandom_range(0, 31);
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom_range(0, 31);
      off = ($urandom_range(0, 32) - 16) * 4;
      a = m_regs[rs1];
      b = m_regs[rs2];
      case (sel)
        0:       taken = (a == b);
        1:       taken = (a != b);
        2:       taken = ($signed(a) < $signed(b));
        3:       taken = !($signed(a) < $signed(b));
        4:       taken = (a < b);
        default: taken = !(a < b);
      endcase
      fetch(enc_b(f3s[sel], rs1, rs2, 13'(off)));
      step();
      m_pc = taken ? (m_pc + 32'(off)) : (m_pc + 32'd4);
      n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL branch_f3_%0d_pc: got %h expected %h", f3s[sel], dut.PC, m_pc); end
    end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 20; k++) begin
      int rd, rs1, off;
      logic [11:0] imm;
      logic [31:0] tgt, link;
      rd   = $urandom_range(0, 31);
      link = m_pc + 32'd4;
      if ((k % 2) == 0) begin
        off = ($urandom_range(0, 64) - 32) * 4;
        fetch(enc_j(rd, 21'(off)));
        tgt = m_pc + 32'(off);
      end else begin
        rs1 = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) rd = rs1;
        imm = 12'($urandom);
        tgt = (m_regs[rs1] + sext12(imm)) & ~32'd1;
        fetch(enc_i(7'b1100111, rd, rs1, 3'd0, imm));
      end
      step();
      if (rd != 0) m_regs[rd] = link;
      m_pc = tgt;
      n_cmp++; if (dut.rf.registers[rd] !== m_regs[rd]) begin n_err++; $display("[TB] FAIL jump_link_x%0d: got %h expected %h", rd, dut.rf.registers[rd], m_regs[rd]); end
      n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL jump_pc: got %h expected %h", dut.PC, m_pc); end
    end
  endtask

  task automatic test_memory();
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 24; k++) begin
      int rs1, rs2, rdf, sel, waits;
      bit is_st;
      logic [11:0] imm;
      logic [31:0] addr, data, ld, ext, ir;
      rs1   = $urandom_range(0, 31);
      rs2   = $urandom_range(0, 31);
      imm   = 12'($urandom);
      waits = $urandom_range(1, 3);
      is_st = ($urandom_range(0, 1) == 1);
      ld    = $urandom;
      addr  = m_regs[rs1] + sext12(imm);
      data  = 32'd0;
      ext   = 32'd0;
      if (is_st) begin
        sel = $urandom_range(0, 2);
        if (sel == 0)      data = m_regs[rs2] & 32'h0000_00FF;
        else if (sel == 1) data = m_regs[rs2] & 32'h0000_FFFF;
        else               data = m_regs[rs2];
        ir = enc_s(3'(sel), rs1, rs2, imm);
      end else begin
        sel = $urandom_range(0, 4);
        case (sel)
          0:       ext = {{24{ld[7]}}, ld[7:0]};
          1:       ext = {{16{ld[15]}}, ld[15:0]};
          2:       ext = ld;
          3:       ext = ld & 32'h0000_00FF;
          default: ext = ld & 32'h0000_FFFF;
        endcase
        ir = enc_i(7'b0000011, $urandom_range(0, 31), rs1, ld_f3[sel], imm);
      end
      rdf = int'(ir[11:7]);
      fetch(ir);
      n_cmp++; if (final_address !== addr) begin n_err++; $display("[TB] FAIL mem_addr: got %h expected %h", final_address, addr); end
      if (is_st) begin
        n_cmp++; if (mem_store !== data) begin n_err++; $display("[TB] FAIL mem_store_sz%0d: got %h expected %h", sel, mem_store, data); end
      end
      n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL mem_freeze_exec: got %b expected 1", dut.Freeze); end
      repeat (waits) step();
      n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL mem_freeze_wait: got %b expected 1", dut.Freeze); end
      d_ack = 1'b1;
      memload = ld;
      #1;
      n_cmp++; if (dut.Freeze !== 1'b0) begin n_err++; $display("[TB] FAIL mem_freeze_ack: got %b expected 0", dut.Freeze); end
      n_cmp++; if (final_address !== addr) begin n_err++; $display("[TB] FAIL mem_addr_hold: got %h expected %h", final_address, addr); end
      step();
      d_ack = 1'b0;
      memload = $urandom;
      if (!is_st && (rdf != 0)) m_regs[rdf] = ext;
      m_pc = m_pc + 32'd4;
      n_cmp++; if (dut.rf.registers[rdf] !== m_regs[rdf]) begin n_err++; $display("[TB] FAIL mem_x%0d: got %h expected %h", rdf, dut.rf.registers[rdf], m_regs[rdf]); end
      n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL mem_pc: got %h expected %h", dut.PC, m_pc); end
    end
  endtask

  task automatic test_nop();
    logic [6:0] opcs [4] = '{7'b0001111, 7'b1110011, 7'b0001011, 7'b1111011};
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ir;
      ir = $urandom;
      ir[6:0] = opcs[k % 4];
      fetch(ir);
      step();
      m_pc = m_pc + 32'd4;
      n_cmp++; if (dut.PC !== m_pc) begin n_err++; $display("[TB] FAIL nop_pc: got %h expected %h", dut.PC, m_pc); end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      n_cmp++; if (dut.rf.registers[i] !== m_regs[i]) begin n_err++; $display("[TB] FAIL sweep_x%0d: got %h expected %h", i, dut.rf.registers[i], m_regs[i]); end
    end
  endtask

  task automatic test_reset_midwait();
    fetch(enc_i(7'b0000011, 4, 1, 3'd2, 12'd4));
    step();
    memload = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    #1;
    m_reset();
    n_cmp++; if (dut.PC !== 32'd0) begin n_err++; $display("[TB] FAIL rstw_pc: got %h expected 0", dut.PC); end
    n_cmp++; if (dut.Freeze !== 1'b1) begin n_err++; $display("[TB] FAIL rstw_freeze: got %b expected 1", dut.Freeze); end
    n_cmp++; if (final_address !== 32'd0) begin n_err++; $display("[TB] FAIL rstw_addr: got %h expected 0", final_address); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++; if (dut.rf.registers[i] !== 32'd0) begin n_err++; $display("[TB] FAIL rstw_x%0d: got %h expected 0", i, dut.rf.registers[i]); end
    end
    @(negedge clk);
    rst = 1'b1;
    d_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    d_ack = 1'b0;
    n_cmp++; if (dut.PC !== 32'd0) begin n_err++; $display("[TB] FAIL rstw_dack_pc: got %h expected 0", dut.PC); end
    n_cmp++; if (dut.rf.registers[4] !== 32'd0) begin n_err++; $display("[TB] FAIL rstw_dack_x4: got %h expected 0", dut.rf.registers[4]); end
    do_i(A_ADD, 1, 0, 12'd3);
    n_cmp++; if (dut.rf.registers[1] !== 32'd3) begin n_err++; $display("[TB] FAIL rstw_resume_x1: got %h expected 3", dut.rf.registers[1]); end
    n_cmp++; if (dut.PC !== 32'd4) begin n_err++; $display("[TB] FAIL rstw_resume_pc: got %h expected 4", dut.PC); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_directed();
    test_dack_ignored();
    test_random_alu();
    test_freeze_alu();
    test_branch();
    test_jumps();
    test_memory();
    test_nop();
    test_sweep();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
